// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse bring-up sequencer: reset, BAT/ID check, sample rate, resolution, enable streaming.
// Drives ps2_rxtx one byte at a time, with per-byte resend, whole-sequence retry and timeouts.
module ps2_mouse_init_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 2_000_000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned MAX_RESEND  = 2,
  parameter logic [7:0]  SAMPLE_RATE = 8'd100,
  parameter logic [7:0]  RESOLUTION  = 8'h02
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  input  logic       tx_done_tick,
  output logic       wr_ps2,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       ready,
  output logic       init_done_tick,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int unsigned TimerW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned RetryW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned ResendW = (MAX_RESEND > 0) ? $clog2(MAX_RESEND + 1) : 1;

  localparam logic [TimerW-1:0]  TimerLast = TimerW'(TIMEOUT_CYC - 1);
  localparam logic [RetryW-1:0]  RetryMax  = RetryW'(MAX_RETRY);
  localparam logic [ResendW-1:0] ResendMax = ResendW'(MAX_RESEND);
  localparam logic [2:0]         LastStep  = 3'd5;

  localparam logic [7:0] RspAck    = 8'hFA;
  localparam logic [7:0] RspResend = 8'hFE;
  localparam logic [7:0] RspBat    = 8'hAA;
  localparam logic [7:0] RspId     = 8'h00;

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrTimeout = 2'd1;
  localparam logic [1:0] ErrByte    = 2'd2;
  localparam logic [1:0] ErrResend  = 2'd3;

  typedef enum logic [2:0] {
    StIdle, StSend, StWaitTx, StWaitAck, StWaitBat, StWaitId, StReady, StErr
  } state_e;

  state_e             state_q;
  logic [2:0]         step_q;
  logic [RetryW-1:0]  retry_q;
  logic [ResendW-1:0] resend_q;
  logic [TimerW-1:0]  timer_q;

  logic       in_wait;
  logic       timeout;
  logic       fail;
  logic [1:0] fail_code;

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    cmd_byte = 8'hFF;
      3'd1:    cmd_byte = 8'hF3;
      3'd2:    cmd_byte = SAMPLE_RATE;
      3'd3:    cmd_byte = 8'hE8;
      3'd4:    cmd_byte = RESOLUTION;
      default: cmd_byte = 8'hF4;
    endcase
  endfunction

  assign in_wait = (state_q == StWaitTx) || (state_q == StWaitAck) ||
                   (state_q == StWaitBat) || (state_q == StWaitId);
  assign timeout = (timer_q == TimerLast);

  // A strobe arriving in the timeout cycle wins over the timeout.
  always_comb begin
    fail      = 1'b0;
    fail_code = ErrNone;
    case (state_q)
      StWaitTx: begin
        if (!tx_done_tick && timeout) begin
          fail      = 1'b1;
          fail_code = ErrTimeout;
        end
      end
      StWaitAck: begin
        if (rx_done_tick) begin
          if (rx_data == RspResend) begin
            if (resend_q >= ResendMax) begin
              fail      = 1'b1;
              fail_code = ErrResend;
            end
          end else if (rx_data != RspAck) begin
            fail      = 1'b1;
            fail_code = ErrByte;
          end
        end else if (timeout) begin
          fail      = 1'b1;
          fail_code = ErrTimeout;
        end
      end
      StWaitBat, StWaitId: begin
        if (rx_done_tick) begin
          if (rx_data != ((state_q == StWaitBat) ? RspBat : RspId)) begin
            fail      = 1'b1;
            fail_code = ErrByte;
          end
        end else if (timeout) begin
          fail      = 1'b1;
          fail_code = ErrTimeout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      step_q         <= 3'd0;
      retry_q        <= '0;
      resend_q       <= '0;
      timer_q        <= '0;
      wr_ps2         <= 1'b0;
      tx_data        <= 8'h00;
      busy           <= 1'b0;
      ready          <= 1'b0;
      init_done_tick <= 1'b0;
      err            <= 1'b0;
      err_code       <= ErrNone;
    end else begin
      wr_ps2         <= 1'b0;
      init_done_tick <= 1'b0;
      if (in_wait && !timeout) begin
        timer_q <= timer_q + 1'b1;
      end

      if (fail) begin
        err_code <= fail_code;
        timer_q  <= '0;
        if (retry_q < RetryMax) begin
          retry_q  <= retry_q + 1'b1;
          step_q   <= 3'd0;
          resend_q <= '0;
          state_q  <= StSend;
          wr_ps2   <= 1'b1;
          tx_data  <= cmd_byte(3'd0);
        end else begin
          state_q <= StErr;
          busy    <= 1'b0;
          err     <= 1'b1;
        end
      end else begin
        unique case (state_q)
          StIdle, StReady, StErr: begin
            if (start) begin
              state_q  <= StSend;
              step_q   <= 3'd0;
              retry_q  <= '0;
              resend_q <= '0;
              err_code <= ErrNone;
              wr_ps2   <= 1'b1;
              tx_data  <= cmd_byte(3'd0);
              busy     <= 1'b1;
              ready    <= 1'b0;
              err      <= 1'b0;
            end
          end
          StSend: begin
            state_q <= StWaitTx;
            timer_q <= '0;
          end
          StWaitTx: begin
            if (tx_done_tick) begin
              state_q <= StWaitAck;
              timer_q <= '0;
            end
          end
          StWaitAck: begin
            if (rx_done_tick) begin
              if (rx_data == RspAck) begin
                if (step_q == 3'd0) begin
                  state_q <= StWaitBat;
                  timer_q <= '0;
                end else if (step_q == LastStep) begin
                  state_q        <= StReady;
                  busy           <= 1'b0;
                  ready          <= 1'b1;
                  init_done_tick <= 1'b1;
                end else begin
                  step_q   <= step_q + 3'd1;
                  resend_q <= '0;
                  state_q  <= StSend;
                  wr_ps2   <= 1'b1;
                  tx_data  <= cmd_byte(step_q + 3'd1);
                end
              end else begin
                // Only a resend request with headroom left reaches here.
                resend_q <= resend_q + 1'b1;
                state_q  <= StSend;
                wr_ps2   <= 1'b1;
                tx_data  <= cmd_byte(step_q);
              end
            end
          end
          StWaitBat: begin
            if (rx_done_tick) begin
              state_q <= StWaitId;
              timer_q <= '0;
            end
          end
          StWaitId: begin
            if (rx_done_tick) begin
              step_q  <= 3'd1;
              state_q <= StSend;
              wr_ps2  <= 1'b1;
              tx_data <= cmd_byte(3'd1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// Directed bench for ps2_mouse_init_ctrl: a scripted mouse, a transaction-level model checked
// every cycle, and literal expectations on the observed command stream.
module tb_ps2_mouse_init_ctrl;

  localparam int unsigned T         = 16;
  localparam int unsigned MaxRetry  = 3;
  localparam int unsigned MaxResend = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done_tick = 1'b0;
  logic       tx_done_tick = 1'b0;
  logic       wr_ps2, busy, ready, init_done_tick, err;
  logic [7:0] tx_data;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  ps2_mouse_init_ctrl #(
    .TIMEOUT_CYC(T), .MAX_RETRY(MaxRetry), .MAX_RESEND(MaxResend),
    .SAMPLE_RATE(8'd100), .RESOLUTION(8'h02)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
    .rx_done_tick(rx_done_tick), .tx_done_tick(tx_done_tick), .wr_ps2(wr_ps2),
    .tx_data(tx_data), .busy(busy), .ready(ready), .init_done_tick(init_done_tick),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [7:0] cmds [6] = '{8'hFF, 8'hF3, 8'd100, 8'hE8, 8'h02, 8'hF4};
  bit         m_active = 0;
  int         m_await = 0;  // 0 byte being written, 1 tx done, 2 ack, 3 BAT, 4 ID
  int         m_idx = 0, m_retries = 0, m_resends = 0;
  int         edge_n = 0, m_deadline = 0;
  bit         cmp_en = 0;
  bit         e_wr = 0, e_busy = 0, e_ready = 0, e_err = 0, e_done = 0;
  logic [7:0] e_tx = 8'h00;
  logic [1:0] e_code = 2'd0;

  task automatic m_issue();
    e_wr    = 1;
    e_tx    = cmds[m_idx];
    m_await = 0;
  endtask

  task automatic m_arm(input int w);
    m_await    = w;
    m_deadline = edge_n + T;
  endtask

  task automatic m_fail(input logic [1:0] c);
    e_code = c;
    if (m_retries < MaxRetry) begin
      m_retries++;
      m_idx     = 0;
      m_resends = 0;
      m_issue();
    end else begin
      m_active = 0;
      e_busy   = 0;
      e_err    = 1;
    end
  endtask

  task automatic m_react(input logic [7:0] b);
    case (m_await)
      1: m_arm(2);
      2: begin
        if (b == 8'hFA) begin
          if (m_idx == 0) m_arm(3);
          else if (m_idx == 5) begin
            m_active = 0; e_busy = 0; e_ready = 1; e_done = 1;
          end else begin
            m_idx++; m_resends = 0; m_issue();
          end
        end else if (b == 8'hFE) begin
          if (m_resends < MaxResend) begin m_resends++; m_issue(); end
          else m_fail(2'd3);
        end else m_fail(2'd2);
      end
      3: if (b == 8'hAA) m_arm(4); else m_fail(2'd2);
      default: if (b == 8'h00) begin m_idx = 1; m_issue(); end else m_fail(2'd2);
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    edge_n++;
    e_wr   = 0;
    e_done = 0;
    if (reset) begin
      m_active = 0; e_busy = 0; e_ready = 0; e_err = 0; e_code = 2'd0; e_tx = 8'h00;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; e_busy = 1; e_ready = 0; e_err = 0; e_code = 2'd0;
        m_retries = 0; m_resends = 0; m_idx = 0;
        m_issue();
      end
    end else if (m_await == 0) m_arm(1);
    else if ((m_await == 1) ? tx_done_tick : rx_done_tick) m_react(rx_data);
    else if (edge_n == m_deadline) m_fail(2'd1);
    cmp_en = 1;
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("wr_ps2", wr_ps2, e_wr);
      check("busy", busy, e_busy);
      check("ready", ready, e_ready);
      check("err", err, e_err);
      check("err_code", err_code, e_code);
      check("init_done_tick", init_done_tick, e_done);
      if (e_wr) check("tx_data", tx_data, e_tx);
    end
  end

  // Observed command stream and completion pulses.
  logic [7:0] tx_log [$];
  int         done_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (wr_ps2 === 1'b1) tx_log.push_back(tx_data);
    if (init_done_tick === 1'b1) done_cnt++;
  end

  // ---------------- scripted mouse ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] exp_b, input string name);
    int k = 0;
    while (wr_ps2 !== 1'b1 && k < 64) begin
      cyc(1);
      k++;
    end
    check(name, (wr_ps2 === 1'b1) ? {24'd0, tx_data} : 32'hDEAD, {24'd0, exp_b});
    cyc(2);
    tx_done_tick = 1'b1;
    cyc(1);
    tx_done_tick = 1'b0;
  endtask

  task automatic reply(input logic [7:0] b);
    cyc(2);
    rx_data      = b;
    rx_done_tick = 1'b1;
    cyc(1);
    rx_done_tick = 1'b0;
  endtask

  task automatic boot_tail();
    reply(8'hFA); reply(8'hAA); reply(8'h00);
  endtask

  task automatic config_tail();
    cmd(8'hF3, "cmd F3"); reply(8'hFA);
    cmd(8'h64, "cmd rate"); reply(8'hFA);
    cmd(8'hE8, "cmd E8"); reply(8'hFA);
    cmd(8'h02, "cmd res"); reply(8'hFA);
    cmd(8'hF4, "cmd F4"); reply(8'hFA);
  endtask

  function automatic int count_byte(input logic [7:0] b);
    int n = 0;
    foreach (tx_log[i]) if (tx_log[i] == b) n++;
    return n;
  endfunction

  initial begin
    logic [7:0] nominal [6] = '{8'hFF, 8'hF3, 8'h64, 8'hE8, 8'h02, 8'hF4};
    int d0;

    cyc(3);
    check("rst wr_ps2", wr_ps2, 1'b0);
    check("rst tx_data", tx_data, 8'h00);
    check("rst busy", busy, 1'b0);
    check("rst ready", ready, 1'b0);
    check("rst err", err, 1'b0);
    check("rst err_code", err_code, 2'd0);
    check("rst done", init_done_tick, 1'b0);
    reset = 1'b0;
    cyc(2);

    // Nominal
    tx_log.delete();
    d0 = done_cnt;
    pulse_start();
    cmd(8'hFF, "cmd FF"); boot_tail();
    config_tail();
    cyc(2);
    check("nom ready", ready, 1'b1);
    check("nom busy", busy, 1'b0);
    check("nom err_code", err_code, 2'd0);
    check("nom done count", done_cnt - d0, 1);
    check("nom tx count", tx_log.size(), 6);
    foreach (nominal[i]) if (i < tx_log.size()) check("nom tx order", tx_log[i], nominal[i]);
    check("model ready", e_ready, 1'b1);

    // Resend on F3, restart from READY
    tx_log.delete();
    pulse_start();
    check("rerun ready drop", ready, 1'b0);
    check("rerun busy", busy, 1'b1);
    cmd(8'hFF, "cmd FF"); boot_tail();
    cmd(8'hF3, "F3 first"); reply(8'hFE);
    config_tail();
    cyc(2);
    check("resend ready", ready, 1'b1);
    check("resend err_code", err_code, 2'd0);
    check("resend F3 count", count_byte(8'hF3), 2);
    check("resend FF count", count_byte(8'hFF), 1);

    // Bad BAT byte forces a full restart
    pulse_start();
    cmd(8'hFF, "cmd FF"); reply(8'hFA); reply(8'hFC);
    cmd(8'hFF, "restart FF");
    check("badbat err_code", err_code, 2'd2);
    check("model code", e_code, 2'd2);
    boot_tail();
    config_tail();
    cyc(2);
    check("badbat ready", ready, 1'b1);

    // Ack arriving exactly in the timeout cycle is accepted
    tx_log.delete();
    pulse_start();
    cmd(8'hFF, "cmd FF");
    cyc(T - 1);
    rx_data      = 8'hFA;
    rx_done_tick = 1'b1;
    cyc(1);
    rx_done_tick = 1'b0;
    check("tie busy", busy, 1'b1);
    reply(8'hAA); reply(8'h00);
    config_tail();
    cyc(2);
    check("tie ready", ready, 1'b1);
    check("tie err_code", err_code, 2'd0);
    check("tie FF count", count_byte(8'hFF), 1);

    // Reset while waiting for the ack to E8
    pulse_start();
    cmd(8'hFF, "cmd FF"); boot_tail();
    cmd(8'hF3, "cmd F3"); reply(8'hFA);
    cmd(8'h64, "cmd rate"); reply(8'hFA);
    cmd(8'hE8, "cmd E8");
    cyc(2);
    reset = 1'b1;
    cyc(1);
    check("abort wr_ps2", wr_ps2, 1'b0);
    check("abort tx_data", tx_data, 8'h00);
    check("abort busy", busy, 1'b0);
    check("abort ready", ready, 1'b0);
    check("abort err", err, 1'b0);
    check("abort err_code", err_code, 2'd0);
    check("abort done", init_done_tick, 1'b0);
    reset = 1'b0;
    tx_log.delete();
    cyc(40);
    check("abort no wr", tx_log.size(), 0);

    // Reset during the SEND cycle
    pulse_start();
    check("send wr", wr_ps2, 1'b1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("send abort wr", wr_ps2, 1'b0);
    tx_log.delete();
    cyc(30);
    check("send abort no wr", tx_log.size(), 0);

    // Silent mouse: retries exhausted
    tx_log.delete();
    pulse_start();
    cyc(120);
    check("to FF count", count_byte(8'hFF), 4);
    check("to tx count", tx_log.size(), 4);
    check("to err", err, 1'b1);
    check("to err_code", err_code, 2'd1);
    check("to busy", busy, 1'b0);

    // Start from ERR clears it
    pulse_start();
    check("restart err", err, 1'b0);
    check("restart err_code", err_code, 2'd0);
    check("restart busy", busy, 1'b1);
    reset = 1'b1;
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
